// File: rtl/hb3_pkg.sv
// Shared types and constants for the HB3 motor emulator.
// Quadrature Gray codes are stored as {enc_a, enc_b}.
package hb3_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        BRAKE   = 2'd2
    } motor_state_e;

    localparam logic [1:0] QUAD_0 = 2'b00;
    localparam logic [1:0] QUAD_1 = 2'b01;
    localparam logic [1:0] QUAD_2 = 2'b11;
    localparam logic [1:0] QUAD_3 = 2'b10;

    function automatic logic [1:0] quad_next(
        input logic [1:0] q,
        input logic       rev
    );
        logic [1:0] n;
        n = QUAD_0;
        unique case (q)
            QUAD_0: n = rev ? QUAD_3 : QUAD_1;
            QUAD_1: n = rev ? QUAD_0 : QUAD_2;
            QUAD_2: n = rev ? QUAD_1 : QUAD_3;
            QUAD_3: n = rev ? QUAD_2 : QUAD_0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/hb3_motor_emulator_quad_encoder_gen.sv
// NCO-driven quadrature encoder: step rate = speed * f_clk / 2^ACC_W.
// The carry is registered, so A/B and position move the cycle after it.
module quad_encoder_gen
    import hb3_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [DUTY_W-1:0] speed,
    input  logic              dir,
    output logic              enc_a,
    output logic              enc_b,
    output logic [31:0]       position
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             step_q;
    logic [1:0]       quad;

    assign sum = {1'b0, acc} + {{(ACC_W + 1 - DUTY_W){1'b0}}, speed};

    always_ff @(posedge clk) begin
        if (!resetN) begin
            acc      <= '0;
            step_q   <= 1'b0;
            quad     <= QUAD_0;
            position <= '0;
        end else begin
            step_q <= 1'b0;
            if (speed != '0) begin
                acc    <= sum[ACC_W-1:0];
                step_q <= sum[ACC_W];
            end
            if (step_q) begin
                quad     <= quad_next(quad, dir);
                position <= dir ? position - 32'd1 : position + 32'd1;
            end
        end
    end

    assign enc_a = quad[1];
    assign enc_b = quad[0];

endmodule

// File: rtl/hb3_motor_emulator.sv
// DC motor + quadrature encoder emulator driven by Pmod HB3 PWM/DIR pins.
// Duty is measured per window, ramped with inertia, then fed to an NCO.
module hb3_motor_emulator
    import hb3_pkg::*;
#(
    parameter int WIN_LOG2 = 16,
    parameter int RAMP_DIV = 1024,
    parameter int ACC_W    = 20
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              enable,
    input  logic              pwm_in,
    input  logic              dir_in,
    output logic              enc_a,
    output logic              enc_b,
    output logic [DUTY_W-1:0] duty_meas,
    output logic [DUTY_W-1:0] speed,
    output logic              dir_active,
    output logic [31:0]       position
);

    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [1:0]          pwm_sync;
    logic [1:0]          dir_sync;
    logic                pwm_s;
    logic                dir_s;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   high_cnt;
    logic [WIN_LOG2:0]   high_final;
    logic [WIN_LOG2:0]   duty_shift;
    logic                win_last;
    logic [RW-1:0]       ramp_cnt;
    logic                tick;
    logic [DUTY_W-1:0]   target;
    motor_state_e        state;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pwm_sync <= '0;
            dir_sync <= '0;
        end else begin
            pwm_sync <= {pwm_sync[0], pwm_in};
            dir_sync <= {dir_sync[0], dir_in};
        end
    end

    assign pwm_s = pwm_sync[1];
    assign dir_s = dir_sync[1];

    // The final window cycle is folded in combinationally before scaling.
    assign win_last   = &win_cnt;
    assign high_final = high_cnt + {{WIN_LOG2{1'b0}}, pwm_s};
    assign duty_shift = high_final >> (WIN_LOG2 - 8);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            win_cnt   <= '0;
            high_cnt  <= '0;
            duty_meas <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (win_last) begin
                high_cnt  <= '0;
                duty_meas <= (|duty_shift[WIN_LOG2:8]) ? 8'hFF
                                                       : duty_shift[7:0];
            end else begin
                high_cnt <= high_final;
            end
        end
    end

    assign tick = (ramp_cnt == RW'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (!resetN) begin
            ramp_cnt <= '0;
        end else if (tick) begin
            ramp_cnt <= '0;
        end else begin
            ramp_cnt <= ramp_cnt + 1'b1;
        end
    end

    assign target = enable ? duty_meas : '0;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= STOPPED;
            speed      <= '0;
            dir_active <= 1'b0;
        end else begin
            unique case (state)
                STOPPED: begin
                    dir_active <= dir_s;
                    if (target != '0) state <= RUN;
                end
                RUN: begin
                    if (dir_s != dir_active) begin
                        state <= BRAKE;
                        if (tick && speed != '0) speed <= speed - 8'd1;
                    end else begin
                        if (tick) begin
                            if (speed < target) speed <= speed + 8'd1;
                            else if (speed > target) speed <= speed - 8'd1;
                        end
                        if (speed == '0 && target == '0) state <= STOPPED;
                    end
                end
                BRAKE: begin
                    if (tick && speed != '0) speed <= speed - 8'd1;
                    if (speed == '0) state <= STOPPED;
                end
                default: state <= STOPPED;
            endcase
        end
    end

    quad_encoder_gen #(
        .ACC_W(ACC_W)
    ) u_quad (
        .clk     (clk),
        .resetN  (resetN),
        .speed   (speed),
        .dir     (dir_active),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .position(position)
    );

endmodule

// File: tb/tb_hb3_motor_emulator.sv
// Directed table-driven bench for hb3_motor_emulator.
// PWM period 16 divides the 256-cycle window, so duty is exact.
module tb_hb3_motor_emulator;
    import hb3_pkg::*;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enable;
    logic        pwm_in;
    logic        dir_in;
    logic        enc_a;
    logic        enc_b;
    logic [7:0]  duty_meas;
    logic [7:0]  speed;
    logic        dir_active;
    logic [31:0] position;

    int n_vec = 0;
    int n_err = 0;
    int high_n = 0;

    typedef struct {
        int           h;
        logic         en;
        logic         dir;
        int           duty;
        int           spd;
        logic         da;
        motor_state_e st;
    } vec_t;

    vec_t vt[7];

    hb3_motor_emulator #(
        .WIN_LOG2(8),
        .RAMP_DIV(4),
        .ACC_W   (10)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .dir_in    (dir_in),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .duty_meas (duty_meas),
        .speed     (speed),
        .dir_active(dir_active),
        .position  (position)
    );

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pwm_in = (ph < high_n);
            ph = (ph + 1) % 16;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name,
                     $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [1:0] model_next(input logic [1:0] q,
                                              input logic rev);
        logic [1:0] fwd[4];
        logic [1:0] r;
        fwd[0] = 2'b00;
        fwd[1] = 2'b01;
        fwd[2] = 2'b11;
        fwd[3] = 2'b10;
        r = 2'b00;
        for (int k = 0; k < 4; k++)
            if (fwd[k] == q) r = rev ? fwd[(k + 3) % 4] : fwd[(k + 1) % 4];
        return r;
    endfunction

    task automatic monitor(input string tag, input logic rev,
                           input int exp_steps);
        logic [1:0]  prev;
        logic [1:0]  cur;
        logic [31:0] p0;
        logic [31:0] pp;
        int          bad;
        bad  = 0;
        prev = {enc_a, enc_b};
        p0   = position;
        pp   = position;
        repeat (800) begin
            cyc(1);
            cur = {enc_a, enc_b};
            if (cur != prev) begin
                if (cur !== model_next(prev, rev)) bad++;
                if (position !== (rev ? pp - 32'd1 : pp + 32'd1)) bad++;
            end else if (position !== pp) begin
                bad++;
            end
            prev = cur;
            pp   = position;
        end
        check({tag, "_seq_errs"}, bad, 0);
        check({tag, "_steps"}, int'(position - p0), exp_steps);
    endtask

    task automatic reversal_check();
        int k;
        int bad;
        k = 0;
        while (k < 3 && dut.state != BRAKE) begin
            cyc(1);
            k++;
        end
        check("rev_brake_state", dut.state, BRAKE);
        bad = 0;
        k = 0;
        while (speed != 0 && k < 1500) begin
            if (dir_active !== 1'b0) bad++;
            cyc(1);
            k++;
        end
        check("rev_speed_zero", speed, 0);
        check("rev_dir_held", bad, 0);
        cyc(3);
        check("rev_dir_flip", dir_active, 1);
    endtask

    initial begin
        logic [1:0]  enc0;
        logic [31:0] pos0;

        vt[0] = '{8,  1'b1, 1'b0, 128, 128, 1'b0, RUN};
        vt[1] = '{16, 1'b1, 1'b0, 255, 255, 1'b0, RUN};
        vt[2] = '{4,  1'b1, 1'b0, 64,  64,  1'b0, RUN};
        vt[3] = '{12, 1'b1, 1'b1, 192, 192, 1'b1, RUN};
        vt[4] = '{15, 1'b0, 1'b1, 240, 0,   1'b1, STOPPED};
        vt[5] = '{1,  1'b1, 1'b0, 16,  16,  1'b0, RUN};
        vt[6] = '{0,  1'b1, 1'b0, 0,   0,   1'b0, STOPPED};

        resetN = 1'b0;
        enable = 1'b0;
        dir_in = 1'b0;
        cyc(3);
        check("rst_duty", duty_meas, 0);
        check("rst_speed", speed, 0);
        check("rst_dir", dir_active, 0);
        check("rst_enc", {enc_a, enc_b}, 0);
        check("rst_pos", position, 0);
        check("rst_state", dut.state, STOPPED);
        resetN = 1'b1;

        for (int i = 0; i < 7; i++) begin
            high_n = vt[i].h;
            enable = vt[i].en;
            dir_in = vt[i].dir;
            if (i == 3) reversal_check();
            cyc(2000);
            check($sformatf("v%0d_duty", i), duty_meas, vt[i].duty);
            check($sformatf("v%0d_speed", i), speed, vt[i].spd);
            check($sformatf("v%0d_dir", i), dir_active, vt[i].da);
            check($sformatf("v%0d_state", i), dut.state, vt[i].st);
            if (i == 0) monitor("fwd128", 1'b0, 100);
            if (i == 3) monitor("rev192", 1'b1, -150);
            if (i == 4) begin
                enc0 = {enc_a, enc_b};
                pos0 = position;
                cyc(200);
                check("freeze_enc", {enc_a, enc_b}, enc0);
                check("freeze_pos", position, pos0);
            end
        end

        high_n = 8;
        cyc(800);
        check("mid_pre_running", speed != 0, 1);
        resetN = 1'b0;
        cyc(3);
        check("mid_duty", duty_meas, 0);
        check("mid_speed", speed, 0);
        check("mid_dir", dir_active, 0);
        check("mid_enc", {enc_a, enc_b}, 0);
        check("mid_pos", position, 0);
        check("mid_state", dut.state, STOPPED);
        resetN = 1'b1;
        cyc(20);
        check("post_enc", {enc_a, enc_b}, 0);
        check("post_pos", position, 0);
        check("post_speed", speed, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
